// File: rtl/simd_issue_if.sv
// simd_issue_if: request-side and ALU-side handshake bundle for the SIMD issue stage.
`default_nettype none

interface simd_issue_if #(
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             in_vld;
    logic [3:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_rdy;

    logic             out_vld;
    logic             out_rdy;
    logic [31:0]      out_a;
    logic [31:0]      out_b;
    logic [3:0]       out_brk;
    logic [3:0]       out_inv;
    logic             out_pass;
    logic             out_pass_sel;

    logic [OCC_W-1:0] occ;
    logic             err_illegal;

    // master: the request producer / ALU consumer side (testbench)
    modport master (
        output in_vld, in_op, in_a, in_b, out_rdy,
        input  in_rdy, out_vld, out_a, out_b, out_brk, out_inv,
               out_pass, out_pass_sel, occ, err_illegal
    );

    // slave: the issue stage itself
    modport slave (
        input  in_vld, in_op, in_a, in_b, out_rdy,
        output in_rdy, out_vld, out_a, out_b, out_brk, out_inv,
               out_pass, out_pass_sel, occ, err_illegal
    );
endinterface

`default_nettype wire

// File: rtl/simd_issue.sv
// simd_issue: decodes SIMD opcodes into per-lane carry control and queues them in a DEPTH-entry FIFO.
// Optional macro SIMD_ISSUE_PASSTHRU_RDY_EN lets a full FIFO accept a push in a popping cycle.
`default_nettype none

module simd_issue #(
    parameter int DEPTH = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    simd_issue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    typedef enum logic [3:0] {
        OP_SEL0     = 4'b0000,
        OP_SEL1     = 4'b0001,
        OP_ADD32    = 4'b0010,
        OP_SUB32    = 4'b0011,
        OP_ADD16    = 4'b0100,
        OP_SUB16    = 4'b0101,
        OP_ADD8     = 4'b0110,
        OP_SUB8     = 4'b0111,
        OP_ADDSUB16 = 4'b1000,
        OP_SUBADD16 = 4'b1001,
        OP_ADDSUB8  = 4'b1010,
        OP_SUBADD8  = 4'b1011
    } op_t;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ_q;
    logic             err_q;

    logic [31:0] mem_a    [DEPTH];
    logic [31:0] mem_b    [DEPTH];
    logic [3:0]  mem_brk  [DEPTH];
    logic [3:0]  mem_inv  [DEPTH];
    logic        mem_pass [DEPTH];
    logic        mem_sel  [DEPTH];

    logic [3:0] dec_brk;
    logic [3:0] dec_inv;
    logic       dec_pass;
    logic       dec_sel;
    logic       dec_legal;

    logic full;
    logic empty;
    logic in_rdy;
    logic push;
    logic wr_en;
    logic pop;

    // Opcode decode; brk marks lanes that start a new element, inv marks subtracting lanes.
    always_comb begin
        dec_brk   = 4'b0000;
        dec_inv   = 4'b0000;
        dec_pass  = 1'b0;
        dec_sel   = 1'b0;
        dec_legal = 1'b1;
        case (op_t'(bus.in_op))
            OP_SEL0:     begin dec_pass = 1'b1; dec_sel = 1'b0; end
            OP_SEL1:     begin dec_pass = 1'b1; dec_sel = 1'b1; end
            OP_ADD32:    begin dec_brk = 4'b0001; dec_inv = 4'b0000; end
            OP_SUB32:    begin dec_brk = 4'b0001; dec_inv = 4'b1111; end
            OP_ADD16:    begin dec_brk = 4'b0101; dec_inv = 4'b0000; end
            OP_SUB16:    begin dec_brk = 4'b0101; dec_inv = 4'b1111; end
            OP_ADD8:     begin dec_brk = 4'b1111; dec_inv = 4'b0000; end
            OP_SUB8:     begin dec_brk = 4'b1111; dec_inv = 4'b1111; end
            OP_ADDSUB16: begin dec_brk = 4'b0101; dec_inv = 4'b0011; end
            OP_SUBADD16: begin dec_brk = 4'b0101; dec_inv = 4'b1100; end
            OP_ADDSUB8:  begin dec_brk = 4'b1111; dec_inv = 4'b0101; end
            OP_SUBADD8:  begin dec_brk = 4'b1111; dec_inv = 4'b1010; end
            default:     dec_legal = 1'b0;
        endcase
    end

    assign full  = (occ_q == OCC_FULL);
    assign empty = (occ_q == '0);

`ifdef SIMD_ISSUE_PASSTHRU_RDY_EN
    // A full FIFO that is popping this cycle frees the slot the push needs.
    assign in_rdy = !rst && (!full || bus.out_rdy);
`else
    assign in_rdy = !rst && !full;
`endif

    assign push  = bus.in_vld && in_rdy;
    assign wr_en = push && dec_legal;
    assign pop   = !empty && bus.out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= push && !dec_legal;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Payload storage carries no reset; contents are only observed while out_vld is high.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_a[wr_ptr]    <= bus.in_a;
            mem_b[wr_ptr]    <= bus.in_b;
            mem_brk[wr_ptr]  <= dec_brk;
            mem_inv[wr_ptr]  <= dec_inv;
            mem_pass[wr_ptr] <= dec_pass;
            mem_sel[wr_ptr]  <= dec_sel;
        end
    end

    assign bus.in_rdy       = in_rdy;
    assign bus.out_vld      = !empty;
    assign bus.out_a        = mem_a[rd_ptr];
    assign bus.out_b        = mem_b[rd_ptr];
    assign bus.out_brk      = mem_brk[rd_ptr];
    assign bus.out_inv      = mem_inv[rd_ptr];
    assign bus.out_pass     = mem_pass[rd_ptr];
    assign bus.out_pass_sel = mem_sel[rd_ptr];
    assign bus.occ          = occ_q;
    assign bus.err_illegal  = err_q;

endmodule

`default_nettype wire

// File: doc/simd_issue.md
Name: simd_issue

Overview:
- Upstream issue stage for the SIMD ALU.
- Accepts raw {opcode, A, B} requests over a valid/ready handshake and decodes each opcode into per-byte-lane carry-chain control.
- Buffers decoded entries in a DEPTH-entry flop FIFO and presents them to the ALU over a second valid/ready handshake.
- Rejects illegal opcodes with an error pulse.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- in_vld  in  1  request valid.
- in_op  in  4  opcode, SIMD op_t encoding.
- in_a  in  32  operand A.
- in_b  in  32  operand B.
- in_rdy  out  1  request ready.
- out_vld  out  1  decoded entry valid.
- out_rdy  in  1  ALU ready.
- out_a  out  32  operand A.
- out_b  out  32  operand B.
- out_brk  out  4  per-lane carry break; bit i=1 means lane i takes its carry-in from out_inv[i], not from lane i-1.
- out_inv  out  4  per-lane subtract: invert B byte; carry-in 1 where out_brk[i]=1.
- out_pass  out  1  select operation, no arithmetic.
- out_pass_sel  out  1  0 selects A, 1 selects B (valid when out_pass=1).
- occ  out  clog2(DEPTH)+1  FIFO occupancy.
- err_illegal  out  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: pointers and occ cleared; out_vld=0, err_illegal=0.
  - in_rdy=0 while rst is asserted.
  - in_rdy=1 from the first cycle after rst deasserts.
  - Storage is not reset. out_a/out_b/out_brk/out_inv/out_pass/out_pass_sel are don't-care while out_vld=0.
- Push: fires when in_vld & in_rdy. Pop: fires when out_vld & out_rdy.
- in_rdy = (occ != DEPTH).
- out_vld = (occ != 0). Outputs are driven from the head entry with no combinational path from in_* to out_*.
- Latency: a push at cycle N is visible at out_vld no earlier than cycle N+1.
- Simultaneous push and pop: occ unchanged; entry order preserved.
  - Full: no push unless the optional feature is enabled.
  - Empty: pop impossible; the push lands and out_vld=1 the next cycle.
- Pointers wrap modulo DEPTH. occ never exceeds DEPTH and never underflows.
- Decode on push, written as {out_brk, out_inv, out_pass, out_pass_sel}, lane 3 first (MSB):
  - SEL0 0000: brk 0000, inv 0000, pass 1, sel 0
  - SEL1 0001: brk 0000, inv 0000, pass 1, sel 1
  - ADD32 0010: brk 0001, inv 0000
  - SUB32 0011: brk 0001, inv 1111
  - ADD16 0100: brk 0101, inv 0000
  - SUB16 0101: brk 0101, inv 1111
  - ADD8 0110: brk 1111, inv 0000
  - SUB8 0111: brk 1111, inv 1111
  - ADDSUB16 1000: brk 0101, inv 0011 (upper half A+B, lower half A-B)
  - SUBADD16 1001: brk 0101, inv 1100
  - ADDSUB8 1010: brk 1111, inv 0101
  - SUBADD8 1011: brk 1111, inv 1010
  - pass=0 for all arithmetic ops.
- Illegal opcode (1100-1111):
  - The handshake completes (in_rdy obeyed) but nothing is written; occ unaffected.
  - err_illegal=1 in cycle N+1 only.
  - Back-to-back illegal pushes give back-to-back pulses.
- Reset mid-operation discards all entries; no pops occur in the rst cycle.

Optional Feature:
- SIMD_ISSUE_PASSTHRU_RDY_EN:
  - Defined: in_rdy = (occ != DEPTH) | out_rdy, so a full FIFO accepts a push in the same cycle it pops; occ stays DEPTH.
  - Undefined: in_rdy = (occ != DEPTH), so a full FIFO stalls input for at least one cycle regardless of out_rdy.

Test Plan:
1. Reset, then one push of op=SUB16 with A=0x12345678, B=0x00010001, out_rdy=1 -> cycle N+1: out_vld=1, out_brk=0101, out_inv=1111, out_pass=0, out_a=0x12345678, out_b=0x00010001; occ returns to 0 after the pop.
2. out_rdy=0 with DEPTH=4 and 5 consecutive ADD8 pushes -> in_rdy=0 after the 4th; occ=4. Then raise out_rdy -> 4 pops in push order, then the 5th entry. Without the macro, in_rdy is low for exactly the first full cycle with out_rdy=1.
3. Macro defined, FIFO full, in_vld=1, out_rdy=1 held for 10 cycles -> in_rdy=1 throughout, occ=4 constant, outputs in order.
4. Push op=4'b1101, then op=SEL1 -> err_illegal=1 one cycle after the illegal push; occ rises only for SEL1; head shows pass=1, sel=1.
5. Sweep all 12 legal opcodes -> each head entry matches the decode table exactly.
6. Assert rst with occ=3 -> next cycle occ=0, out_vld=0, err_illegal=0; in_rdy=1 the cycle after rst deasserts.
